sdram_req_arbiter: RTL
======================

SDRAM_REQ_ARBITER -- requirements
Module: sdram_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 23: width of the SDRAM controller user address.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles spent in WAIT_RD before the read is aborted; range 1..255.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 c_req / c_we  in  1 / 1  code-port request and write-enable; level signals.
REQ-006 c_adr / c_wdat / c_sel  in  32 / 32 / 4  code-port byte address, write data and byte mask.
REQ-007 c_ack / c_err / c_rdat  out  1 / 1 / 32  code-port completion pulse, timeout flag and read data.
REQ-008 d_req, d_we, d_adr, d_wdat, d_sel, d_ack, d_err, d_rdat  same widths and directions as the c_* ports  data-port equivalents.
REQ-009 m_in_valid / m_rw / m_addr / m_wdata / m_mask  out  1 / 1 / ADDR_W / 32 / 4  command to the SDRAM controller; m_rw=1 means write.
REQ-010 m_busy / m_out_valid / m_rdata  in  1 / 1 / 32  controller busy flag, read-data strobe and read data.
REQ-011 grant  out  2  current owner: 00 none, 01 code, 10 data.

Function
REQ-012 Bank remap: code port uses bank {1'b1, adr[8]} and data port uses bank {1'b0, adr[8]}; m_addr = {adr[22:10], bank, adr[7:0]}; adr[9] and adr[31:23] are ignored.
REQ-013 FSM states: IDLE, ISSUE, WAIT_RD, ACK.
REQ-014 IDLE: if any req is high, pick a winner, latch its we/adr/wdat/sel, set grant, and go to ISSUE on the next edge; otherwise stay in IDLE with grant=00.
REQ-015 Tie-break on simultaneous requests is round-robin: the port not granted last wins; last_grant resets to data, so code wins the first tie.
REQ-016 ISSUE: hold m_in_valid=1 with the latched command.
- Acceptance is m_in_valid && !m_busy in the same cycle.
- On a write acceptance, go to ACK.
- On a read acceptance, go to WAIT_RD and clear the timeout counter.
- While m_busy=1, stay in ISSUE with the command held stable.
REQ-017 m_in_valid shall be 0 in every state except ISSUE; m_mask = latched sel on writes and 4'b0000 on reads.
REQ-018 WAIT_RD: on m_out_valid=1, capture m_rdata into the granted port's rdat and go to ACK.
- Otherwise the counter increments each cycle.
- When the counter equals TIMEOUT, go to ACK with err=1 and rdat=32'h0.
REQ-019 ACK:
- Assert the granted port's ack for exactly one cycle; err is valid in that same cycle.
- Update last_grant.
- Return to IDLE.
- Requests are not sampled in ACK.
REQ-020 Requesters hold req and the command stable until ack and deassert or change them the cycle after; a req still high in IDLE is a new request.
REQ-021 Latency from req high in IDLE:
- Write: ack 2 cycles later when m_busy=0.
- Read: ack 1 cycle after m_out_valid.
REQ-022 m_out_valid outside WAIT_RD shall be ignored; rdat registers keep their last value until the next read completion on that port.
REQ-023 The non-granted port's ack and err stay 0 throughout.

Reset
REQ-024 rst_n low shall force immediately:
- FSM to IDLE.
- grant=00, last_grant=data, counter=0.
- All ack, err, m_in_valid and m_rw to 0.
- m_addr, m_wdata, m_mask, c_rdat and d_rdat to 0.
REQ-025 Reset mid-transaction abandons it with no ack; a later m_out_valid is ignored per REQ-022.

Configuration
REQ-026 Macro SDRAM_ARB_CODE_PRIORITY_EN:
- Defined: the code port always wins simultaneous requests; last_grant is still maintained but unused.
- Undefined: round-robin per REQ-015.

Verification
REQ-027 Write: d_req=1, d_we=1, d_adr=32'h3000_0504, d_sel=4'hF, m_busy=0 -> m_in_valid in cycle 1 with m_addr={13'h1,2'b01,8'h04}, m_rw=1; d_ack in cycle 2.
REQ-028 Read remap: c_req=1, c_we=0, c_adr=32'h3800_0200; m_out_valid with m_rdata=32'hCAFE_F00D 5 cycles after acceptance -> m_addr bank=2'b10, m_mask=0, c_rdat=32'hCAFE_F00D, c_ack 1 cycle later, c_err=0.
REQ-029 Tie: c_req and d_req both held high for three transactions -> grant order code, data, code (round-robin); with SDRAM_ARB_CODE_PRIORITY_EN defined, code wins each tie while it keeps requesting.
REQ-030 Backpressure: m_busy=1 for 4 cycles during ISSUE -> m_in_valid and the command held stable for 4 cycles; accepted in cycle 5.
REQ-031 Timeout: TIMEOUT=8, read accepted, m_out_valid never asserted -> ack with err=1, rdat=0 after 8 cycles in WAIT_RD; the FSM returns to IDLE.
REQ-032 Reset in WAIT_RD, then m_out_valid 2 cycles after rst_n rises -> no ack, grant=00, FSM stays in IDLE.

Source files
------------

// File: rtl/sdram_req_arbiter.sv
// rtl/sdram_req_arbiter.sv - two-port (code/data) request arbiter in front of an SDRAM controller; optional macro SDRAM_ARB_CODE_PRIORITY_EN
module sdram_req_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // code port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_adr,
  input  logic [31:0]       c_wdat,
  input  logic [3:0]        c_sel,
  output logic              c_ack,
  output logic              c_err,
  output logic [31:0]       c_rdat,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_adr,
  input  logic [31:0]       d_wdat,
  input  logic [3:0]        d_sel,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdat,
  // SDRAM controller command side
  output logic              m_in_valid,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_mask,
  input  logic              m_busy,
  input  logic              m_out_valid,
  input  logic [31:0]       m_rdata,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, ACK} state_t;

  state_t      state, state_nxt;
  logic        last_data;   // 1: data port was granted most recently
  logic [7:0]  cnt;
  logic        err_q;
  logic        pick_data;
  logic        any_req;
  logic        sel_we;
  logic [31:0] sel_adr;
  logic [31:0] sel_wdat;
  logic [3:0]  sel_sel;
  logic [22:0] remap_adr;
  logic        rd_timeout;
  logic        unused_adr;

  assign any_req = c_req | d_req;

  // Winner selection for the IDLE cycle; code always wins ties when prioritised
`ifdef SDRAM_ARB_CODE_PRIORITY_EN
  assign pick_data = d_req & ~c_req;
`else
  assign pick_data = d_req & (~c_req | ~last_data);
`endif

  assign sel_we   = pick_data ? d_we   : c_we;
  assign sel_adr  = pick_data ? d_adr  : c_adr;
  assign sel_wdat = pick_data ? d_wdat : c_wdat;
  assign sel_sel  = pick_data ? d_sel  : c_sel;

  // Code lives in banks 2/3, data in banks 0/1; adr[8] picks within the pair
  assign remap_adr  = {sel_adr[22:10], ~pick_data, sel_adr[8], sel_adr[7:0]};
  assign unused_adr = ^{sel_adr[31:23], sel_adr[9]};

  // Counter value TIMEOUT-1 marks the last permitted WAIT_RD cycle
  assign rd_timeout = (cnt == 8'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and port-facing strobes
  always_comb begin
    state_nxt  = state;
    m_in_valid = 1'b0;
    c_ack      = 1'b0;
    d_ack      = 1'b0;
    c_err      = 1'b0;
    d_err      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        m_in_valid = 1'b1;
        if (!m_busy) state_nxt = m_rw ? ACK : WAIT_RD;
      end
      WAIT_RD: begin
        if (m_out_valid || rd_timeout) state_nxt = ACK;
      end
      ACK: begin
        c_ack     = grant[0];
        d_ack     = grant[1];
        c_err     = grant[0] & err_q;
        d_err     = grant[1] & err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, grant bookkeeping, read-data capture and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= 2'b00;
      last_data <= 1'b1;
      cnt       <= 8'd0;
      err_q     <= 1'b0;
      m_rw      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= 32'h0;
      m_mask    <= 4'h0;
      c_rdat    <= 32'h0;
      d_rdat    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant   <= pick_data ? 2'b10 : 2'b01;
            m_rw    <= sel_we;
            m_addr  <= ADDR_W'(remap_adr);
            m_wdata <= sel_wdat;
            m_mask  <= sel_we ? sel_sel : 4'h0;
            err_q   <= 1'b0;
          end
        end
        ISSUE: begin
          if (!m_busy) cnt <= 8'd0;
        end
        WAIT_RD: begin
          if (m_out_valid) begin
            err_q <= 1'b0;
            if (grant[1]) d_rdat <= m_rdata;
            else          c_rdat <= m_rdata;
          end else if (rd_timeout) begin
            err_q <= 1'b1;
            if (grant[1]) d_rdat <= 32'h0;
            else          c_rdat <= 32'h0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ACK: begin
          last_data <= grant[1];
          grant     <= 2'b00;
          err_q     <= 1'b0;
        end
        default: grant <= 2'b00;
      endcase
    end
  end

endmodule
